// File: rtl/status_flag_unit_pkg.sv
// Shared types for the NZCV status writer: op classes, flag bits, FSM states.
// STATUS_FLAG_BYPASS_EN (optional) adds the status_next bypass output.
package status_flag_unit_pkg;

  typedef enum logic [1:0] {
    OPC_LOGIC = 2'b00,
    OPC_ADD   = 2'b01,
    OPC_SUB   = 2'b10,
    OPC_MUL   = 2'b11
  } opc_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_WAIT
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE-side bundle into the status flag writer and its flag outputs.
// STATUS_FLAG_BYPASS_EN adds status_next.
interface status_flag_if
  import status_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             exe_valid;
  logic             s_bit;
  logic             cond_pass;
  opc_e             op_class;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH-1:0] mul_result;
  logic             stall;
  logic             flush;
  logic             msr_we;
  logic [3:0]       msr_data;
  logic [3:0]       statusReg;
  logic             status_pending;
  logic             protocol_err;
`ifdef STATUS_FLAG_BYPASS_EN
  logic [3:0]       status_next;
`endif

  modport slave (
    input  exe_valid, s_bit, cond_pass, op_class,
    input  op_a, op_b, alu_result, alu_carry,
    input  mul_result, stall, flush,
    input  msr_we, msr_data,
`ifdef STATUS_FLAG_BYPASS_EN
    output status_next,
`endif
    output statusReg, status_pending, protocol_err
  );

  modport master (
    output exe_valid, s_bit, cond_pass, op_class,
    output op_a, op_b, alu_result, alu_carry,
    output mul_result, stall, flush,
    output msr_we, msr_data,
`ifdef STATUS_FLAG_BYPASS_EN
    input  status_next,
`endif
    input  statusReg, status_pending, protocol_err
  );

endinterface

// File: rtl/status_flag_unit_flag_calc.sv
// Combinational NZCV computation for logical/add/sub results.
// Multiply flags are resolved later in the top, so mul passes old flags.
module flag_calc
  import status_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  opc_e             op_class_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             carry_i,
  input  logic [3:0]       flags_i,
  output logic [3:0]       flags_o
);

  logic neg;
  logic zero;
  logic a_s;
  logic b_s;
  logic unused_low;

  assign neg  = r_i[WIDTH-1];
  assign zero = (r_i == '0);
  assign a_s  = a_i[WIDTH-1];
  assign b_s  = b_i[WIDTH-1];
  assign unused_low = ^{a_i[WIDTH-2:0], b_i[WIDTH-2:0]};

  always_comb begin
    flags_o = flags_i;
    unique case (1'b1)
      op_class_i == OPC_LOGIC: begin
        flags_o[FLAG_N] = neg;
        flags_o[FLAG_Z] = zero;
        flags_o[FLAG_C] = carry_i;
      end
      op_class_i == OPC_ADD: begin
        flags_o[FLAG_N] = neg;
        flags_o[FLAG_Z] = zero;
        flags_o[FLAG_C] = carry_i;
        flags_o[FLAG_V] = (a_s == b_s) & (neg != a_s);
      end
      op_class_i == OPC_SUB: begin
        flags_o[FLAG_N] = neg;
        flags_o[FLAG_Z] = zero;
        flags_o[FLAG_C] = carry_i;
        flags_o[FLAG_V] = (a_s != b_s) & (neg != a_s);
      end
      op_class_i == OPC_MUL: begin
        flags_o = flags_i;
      end
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV status register writer with multi-cycle multiply tracking.
// STATUS_FLAG_BYPASS_EN exposes the next-edge flag value as status_next.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  status_flag_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [3:0]       alu_flags;
  logic [3:0]       mul_flags;
  logic             take;

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .op_class_i (bus.op_class),
    .a_i        (bus.op_a),
    .b_i        (bus.op_b),
    .r_i        (bus.alu_result),
    .carry_i    (bus.alu_carry),
    .flags_i    (flags_q),
    .flags_o    (alu_flags)
  );

  assign take = bus.exe_valid & bus.s_bit & bus.cond_pass
              & ~bus.stall & ~bus.flush;

  assign mul_flags = {bus.mul_result[WIDTH-1],
                      bus.mul_result == '0,
                      flags_q[FLAG_C], flags_q[FLAG_V]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take && bus.op_class == OPC_MUL) begin
          state_d = ST_MUL_WAIT;
          cnt_d   = CNT_W'(MUL_LAT);
        end else if (take) begin
          flags_d = alu_flags;
        end
      end
      ST_MUL_WAIT: begin
        if (take) err_d = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          flags_d = mul_flags;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    // Direct write wins over everything, including flush and mul completion
    if (bus.msr_we) begin
      flags_d = bus.msr_data;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.statusReg      = flags_q;
  assign bus.status_pending = (state_q == ST_MUL_WAIT);
  assign bus.protocol_err   = err_q;
`ifdef STATUS_FLAG_BYPASS_EN
  assign bus.status_next    = flags_d;
`endif

endmodule
